pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the 32-bit two-level lookahead adder.
- Splits a WIDTH-bit operation into STAGES segments. Each segment is resolved in its own register stage, with carry rippling stage-to-stage through registers.
- Valid/ready streaming interface and status flags (carry, signed overflow, zero).
- Sits between the ALU operand latch and writeback; multi-cycle ALU ops and address generation reuse it.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of STAGES.
- STAGES, 2, pipeline segments (1..8). Latency equals STAGES. Segment width SEG = WIDTH/STAGES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- iC  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+iC; 1 = A-B-iC.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- S  out  WIDTH  sum/difference.
- oC  out  1  carry-out (sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  S == 0.

Behaviour:
- Operand conditioning at input:
  - Beff = sub ? ~B : B.
  - cin = sub ? ~iC : iC.
  - All arithmetic is modulo 2^WIDTH.
- Stage k (0..STAGES-1):
  - Computes segment k, bits [(k+1)*SEG-1 : k*SEG], via adder_segment using carry from stage k-1's register (stage 0 uses cin).
  - Registers the segment sum, its carry-out, the already-finished lower sums, and the still-unused upper A/Beff slices.
- Single global advance: adv = !out_valid || out_ready.
  - All stage registers, including valid bits, load only when adv=1.
  - in_ready = adv (combinational from out_valid/out_ready).
- Beat acceptance and latency:
  - Beat accepted when in_valid && in_ready.
  - Appears on S/oC/ovf/zero with out_valid=1 exactly STAGES advancing cycles later.
  - Throughput: 1 beat/cycle when out_ready is held high.
  - Bubbles are not squeezed; invalid slots propagate.
- Stall: when out_valid=1 && out_ready=0, every register holds and outputs stay stable.
- Flags, all registered with S:
  - oC = final-stage carry-out.
  - ovf = (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]). The sign bits are carried down the pipeline.
  - zero = (S == 0).
- Reset, asynchronous at any time (including mid-stream):
  - All valid bits cleared; S = 0, oC = 0, ovf = 0, zero = 0, out_valid = 0.
  - Beats in flight are discarded.
  - in_ready = 1 once out_valid = 0.
- Boundaries:
  - STAGES=1 gives a registered single-cycle adder.
  - Carry into bit WIDTH is not kept except as oC.
  - in_valid while in_ready=0: beat is not taken, and the source must hold it.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- Defined: when ovf=1, S is clamped to the signed limit: 0x7FF..F if A[W-1]=0, else 0x800..0. zero is recomputed from the clamped S; oC and ovf are unchanged. Clamp is applied in the final stage with no added latency.
- Undefined: S is the wrapped result; no clamp logic is present.

Decomposition:
- Package addsub_pkg holds:
  - constants MAX_STAGES = 8;
  - a function computing SEG;
  - a typedef for the per-stage payload struct (valid, partial sum, carry, upper operand slices, sign bits).
- Sub-module adder_segment, parametrised by SEG:
  - 4-bit lookahead groups with group P/G;
  - outputs sum and carry-out;
  - instantiated once per stage.

Test Plan (WIDTH=32, STAGES=2, out_ready=1 unless stated):
- Add: A=0x0000FFFF, B=0x00000001, iC=0, sub=0 -> after 2 cycles S=0x00010000, oC=0, ovf=0, zero=0. This exercises the inter-stage carry.
- Sub: A=5, B=5, iC=0, sub=1 -> S=0, zero=1, oC=1. Then A=3, B=5 -> S=0xFFFFFFFE, oC=0.
- Overflow: A=0x7FFFFFFF, B=1 -> S=0x80000000, ovf=1. With ADDSUB_SATURATE_EN: S=0x7FFFFFFF, ovf=1.
- Back-to-back stream of 8 beats with out_ready=1 -> 8 consecutive out_valid cycles, in order. Drop out_ready for 3 cycles mid-stream -> in_ready=0 and S held; no beat lost or duplicated.
- Full carry chain: A=0xFFFFFFFF, B=0, iC=1 -> S=0, oC=1, zero=1.
- Assert rst with 2 beats in flight -> out_valid=0 and S=0 immediately; after release, a new beat returns its correct result after 2 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage limits, segment sizing
// and the per-stage control payload that travels alongside the data slices.
package addsub_pkg;

    localparam int MAX_STAGES = 8;

    // Data slices (partial sum, upper operand slices) depend on WIDTH, so they sit
    // next to this struct in each stage rather than inside it.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sign_a;
        logic sign_b;
    } stage_ctl_t;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit carry-lookahead adder built from 4-bit groups with group propagate/generate;
// a partial last group is zero-padded and the carry is taken at bit SEG.
module adder_segment #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    localparam int NG = (SEG + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] ap, bp, p, g;
    logic [PW:0]   c;
    logic [NG:0]   gc;
    logic [NG-1:0] gp, gg;

    assign ap = PW'(a);
    assign bp = PW'(b);

    always_comb begin
        p  = ap ^ bp;
        g  = ap & bp;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        for (int grp = 0; grp < NG; grp++) begin
            gp[grp] = &p[grp*4 +: 4];
            gg[grp] = g[grp*4+3]
                    | (p[grp*4+3] & g[grp*4+2])
                    | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                    | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]);
        end
        gc[0] = cin;
        for (int grp = 0; grp < NG; grp++)
            gc[grp+1] = gg[grp] | (gp[grp] & gc[grp]);
        for (int grp = 0; grp < NG; grp++) begin
            c[grp*4] = gc[grp];
            for (int i = 1; i < 4; i++)
                c[grp*4+i] = g[grp*4+i-1] | (p[grp*4+i-1] & c[grp*4+i-1]);
        end
        c[PW] = gc[NG];
    end

    assign sum  = p[SEG-1:0] ^ c[SEG-1:0];
    assign cout = c[SEG];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined carry-lookahead add/sub, one SEG-bit segment per register stage with a
// single global advance. Define ADDSUB_SATURATE_EN to clamp overflowing results.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             iC,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             oC,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = seg_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > MAX_STAGES || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: bad WIDTH/STAGES combination");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] s_q;
    logic             vld_q, oc_q, ovf_q, zero_q;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, s_next;
        stage_ctl_t       c_in;
        logic [SEG-1:0]   seg_sum;
        logic             seg_co;

        if (k == 0) begin : g_src
            assign a_in = A;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = '{valid: in_valid, carry: sub ? ~iC : iC,
                            sign_a: A[WIDTH-1], sign_b: b_eff[WIDTH-1]};
        end else begin : g_src
            assign a_in = g_stage[k-1].g_reg.a_r;
            assign b_in = g_stage[k-1].g_reg.b_r;
            assign s_in = g_stage[k-1].g_reg.s_r;
            assign c_in = g_stage[k-1].g_reg.c_r;
        end

        adder_segment #(.SEG(SEG)) u_seg (
            .a   (a_in[k*SEG +: SEG]),
            .b   (b_in[k*SEG +: SEG]),
            .cin (c_in.carry),
            .sum (seg_sum),
            .cout(seg_co)
        );

        always_comb begin
            s_next = s_in;
            s_next[k*SEG +: SEG] = seg_sum;
        end

        if (k == STAGES - 1) begin : g_reg
            logic             ovf_n;
            logic [WIDTH-1:0] s_fin;

            assign ovf_n = (c_in.sign_a == c_in.sign_b) && (s_next[WIDTH-1] != c_in.sign_a);
`ifdef ADDSUB_SATURATE_EN
            assign s_fin = !ovf_n ? s_next :
                           c_in.sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
            assign s_fin = s_next;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q  <= 1'b0;
                    s_q    <= '0;
                    oc_q   <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    vld_q  <= c_in.valid;
                    s_q    <= s_fin;
                    oc_q   <= seg_co;
                    ovf_q  <= ovf_n;
                    zero_q <= (s_fin == '0);
                end
            end
        end else begin : g_reg
            logic [WIDTH-1:0] a_r, b_r, s_r;
            stage_ctl_t       c_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                    s_r <= '0;
                    c_r <= '0;
                end else if (adv) begin
                    a_r <= a_in;
                    b_r <= b_in;
                    s_r <= s_next;
                    c_r <= '{valid: c_in.valid, carry: seg_co,
                             sign_a: c_in.sign_a, sign_b: c_in.sign_b};
                end
            end
        end
    end

    assign out_valid = vld_q;
    assign S         = s_q;
    assign oC        = oc_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
